// File: rtl/vram_arbiter.sv
// Single-port video memory arbiter: pixel reads always win, CPU writes wait in an in-order FIFO.
// Optional macro VRAM_ARB_FORWARD_EN returns pending write data to matching reads.
module vram_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                         CLK100MHz,
    input  logic                         rst,
    input  logic                         rd_req,
    input  logic [ADDRESS_WIDTH-1:0]     rd_addr,
    output logic                         rd_valid,
    output logic [7:0]                   rd_data,
    input  logic                         wr_req,
    input  logic [ADDRESS_WIDTH-1:0]     wr_addr,
    input  logic [7:0]                   wr_data,
    output logic                         wr_full,
    output logic [$clog2(FIFO_DEPTH):0]  wr_level,
    output logic                         wr_overflow,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    output logic [7:0]                   mem_wdata,
    input  logic [7:0]                   mem_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [7:0]               data;
    } wr_entry_t;

    wr_entry_t        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic             rd_p0_q;
    logic             rd_p1_q;

    logic             issue_rd;
    logic             issue_wr;
    logic             push;
    logic [LVL_W-1:0] level_nxt;
    wr_entry_t        head_entry;
    logic [7:0]       ret_data;

    // Arbitration looks at occupancy before any push on this edge
    always_comb begin
        issue_rd   = rd_req;
        issue_wr   = !rd_req && (wr_level != '0);
        push       = wr_req && !wr_full;
        head_entry = fifo_q[head_q];
        level_nxt  = wr_level;
        if (push && !issue_wr) begin
            level_nxt = wr_level + LVL_W'(1);
        end else if (!push && issue_wr) begin
            level_nxt = wr_level - LVL_W'(1);
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (push) begin
            fifo_q[tail_q] <= '{addr: wr_addr, data: wr_data};
        end
    end

`ifdef VRAM_ARB_FORWARD_EN
    logic             fwd_hit;
    logic [7:0]       fwd_data;
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_hit_p0_q;
    logic             fwd_hit_p1_q;
    logic [7:0]       fwd_data_p0_q;
    logic [7:0]       fwd_data_p1_q;

    // Scan oldest to newest so the newest matching entry wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((LVL_W'(i) < wr_level) && (fifo_q[fwd_idx].addr == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_q[fwd_idx].data;
            end
        end
    end

    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            fwd_hit_p0_q  <= 1'b0;
            fwd_hit_p1_q  <= 1'b0;
            fwd_data_p0_q <= '0;
            fwd_data_p1_q <= '0;
        end else begin
            fwd_hit_p0_q  <= rd_req && fwd_hit;
            fwd_data_p0_q <= fwd_data;
            fwd_hit_p1_q  <= fwd_hit_p0_q;
            fwd_data_p1_q <= fwd_data_p0_q;
        end
    end

    assign ret_data = fwd_hit_p1_q ? fwd_data_p1_q : mem_rdata;
`else
    assign ret_data = mem_rdata;
`endif

    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            wr_level    <= '0;
            wr_full     <= 1'b0;
            wr_overflow <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_p0_q     <= 1'b0;
            rd_p1_q     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (issue_wr) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            wr_level <= level_nxt;
            wr_full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
            if (wr_req && wr_full) begin
                wr_overflow <= 1'b1;
            end

            mem_en <= issue_rd || issue_wr;
            mem_we <= issue_wr;
            if (issue_rd) begin
                mem_addr <= rd_addr;
            end else if (issue_wr) begin
                mem_addr  <= head_entry.addr;
                mem_wdata <= head_entry.data;
            end

            // Memory returns data one cycle after the strobe; capture it on the following edge
            rd_p0_q  <= issue_rd;
            rd_p1_q  <= rd_p0_q;
            rd_valid <= rd_p1_q;
            if (rd_p1_q) begin
                rd_data <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand sequences and a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;
`ifdef VRAM_ARB_FORWARD_EN
    localparam logic [7:0] FWD_EXP = 8'h33;
`else
    localparam logic [7:0] FWD_EXP = 8'h11;
`endif

    logic          CLK100MHz = 1'b0;
    logic          rst = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_full;
    logic [LW-1:0] wr_level;
    logic          wr_overflow;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;

    always #5 CLK100MHz = ~CLK100MHz;

    vram_arbiter #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK100MHz(CLK100MHz), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .wr_level(wr_level), .wr_overflow(wr_overflow),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return (a == 12'h020) ? 8'h11 : (a[7:0] ^ 8'h3C);
    endfunction

    // Synchronous single-port memory
    bit [7:0] ram [1<<AW];
    bit       ram_vld [1<<AW];
    always @(posedge CLK100MHz) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_vld[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: pending-write queue, architectural memory, return queue
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } went_t;
    typedef struct { int due; logic [7:0] data; } ret_t;
    went_t         wq[$];
    ret_t          rq[$];
    bit [7:0]      ref_mem [1<<AW];
    bit            ref_vld [1<<AW];
    int            cyc = 0;
    bit            infl = 1'b0;
    went_t         infl_e;
    went_t         m_w;
    ret_t          m_r;
    int            m_pre;
    logic          e_en = 1'b0, e_we = 1'b0, e_rv = 1'b0, e_ovf = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [7:0]    e_wdata = '0, e_rdata = '0;

    always @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            wq.delete();
            rq.delete();
            infl    = 1'b0;
            e_en    = 1'b0;
            e_we    = 1'b0;
            e_rv    = 1'b0;
            e_ovf   = 1'b0;
            e_addr  = '0;
            e_wdata = '0;
        end else begin
            cyc++;
            if (infl) begin
                ref_mem[infl_e.addr] = infl_e.data;
                ref_vld[infl_e.addr] = 1'b1;
            end
            infl = 1'b0;
            e_rv = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_rv    = 1'b1;
                e_rdata = rq[0].data;
                void'(rq.pop_front());
            end
            m_pre = wq.size();
            e_en  = 1'b0;
            e_we  = 1'b0;
            if (rd_req) begin
                m_r.due  = cyc + 2;
                m_r.data = ref_vld[rd_addr] ? ref_mem[rd_addr] : init_val(rd_addr);
`ifdef VRAM_ARB_FORWARD_EN
                foreach (wq[i]) if (wq[i].addr == rd_addr) m_r.data = wq[i].data;
`endif
                rq.push_back(m_r);
                e_en   = 1'b1;
                e_addr = rd_addr;
            end else if (m_pre > 0) begin
                infl_e  = wq.pop_front();
                infl    = 1'b1;
                e_en    = 1'b1;
                e_we    = 1'b1;
                e_addr  = infl_e.addr;
                e_wdata = infl_e.data;
            end
            if (wr_req) begin
                if (m_pre < DEPTH) begin
                    m_w.addr = wr_addr;
                    m_w.data = wr_data;
                    wq.push_back(m_w);
                end else begin
                    e_ovf = 1'b1;
                end
            end
        end
    end

    task automatic model_check();
        if (rst) begin
            check("m_en", 32'(mem_en), 32'(e_en));
            check("m_we", 32'(mem_we), 32'(e_we));
            check("m_addr", 32'(mem_addr), 32'(e_addr));
            check("m_wdata", 32'(mem_wdata), 32'(e_wdata));
            check("m_level", 32'(wr_level), 32'(wq.size()));
            check("m_full", 32'(wr_full), 32'(wq.size() == DEPTH));
            check("m_ovf", 32'(wr_overflow), 32'(e_ovf));
            check("m_rv", 32'(rd_valid), 32'(e_rv));
            if (e_rv) check("m_rdata", 32'(rd_data), 32'(e_rdata));
        end
    endtask

    task automatic tick();
        @(negedge CLK100MHz);
        model_check();
    endtask

    task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wr,
                         input logic [AW-1:0] wa, input logic [7:0] wd);
        rd_req  = rd;
        rd_addr = ra;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"}, 32'(mem_en), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_level"}, 32'(wr_level), 32'd0);
        check({tag, "_full"}, 32'(wr_full), 32'd0);
        check({tag, "_ovf"}, 32'(wr_overflow), 32'd0);
        check({tag, "_rv"}, 32'(rd_valid), 32'd0);
        check({tag, "_rdata"}, 32'(rd_data), 32'd0);
    endtask

    // Row: outputs expected at this negedge, then inputs driven for the next edge
    typedef struct {
        logic en, we; logic [AW-1:0] ma; logic [7:0] md; logic [LW-1:0] lv;
        logic fu, ov, rv; logic [7:0] rdat;
        logic rd; logic [AW-1:0] ra; logic wr; logic [AW-1:0] wa; logic [7:0] wd;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic we, input logic [AW-1:0] ma,
                                input logic [7:0] md, input logic [LW-1:0] lv, input logic fu,
                                input logic ov, input logic rv, input logic [7:0] rdat,
                                input logic rd, input logic [AW-1:0] ra, input logic wr,
                                input logic [AW-1:0] wa, input logic [7:0] wd);
        vec_t v;
        v.en = en; v.we = we; v.ma = ma; v.md = md; v.lv = lv; v.fu = fu; v.ov = ov;
        v.rv = rv; v.rdat = rdat; v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    vec_t tbl[25];
    int   rd_pct, wr_pct;

    initial begin
        tbl[0]  = mk(0,0,12'h000,8'h00,3'd0,0,0,0,8'h00, 0,12'h000,1,12'h010,8'h5A);
        tbl[1]  = mk(0,0,12'h000,8'h00,3'd1,0,0,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[2]  = mk(1,1,12'h010,8'h5A,3'd0,0,0,0,8'h00, 1,12'h010,0,12'h000,8'h00);
        tbl[3]  = mk(1,0,12'h010,8'h5A,3'd0,0,0,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[4]  = mk(0,0,12'h010,8'h5A,3'd0,0,0,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[5]  = mk(0,0,12'h010,8'h5A,3'd0,0,0,1,8'h5A, 1,12'h100,1,12'h030,8'hC3);
        tbl[6]  = mk(1,0,12'h100,8'h5A,3'd1,0,0,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[7]  = mk(1,1,12'h030,8'hC3,3'd0,0,0,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[8]  = mk(0,0,12'h030,8'hC3,3'd0,0,0,1,8'h3C, 1,12'h200,1,12'h040,8'h01);
        tbl[9]  = mk(1,0,12'h200,8'hC3,3'd1,0,0,0,8'h00, 1,12'h201,1,12'h041,8'h02);
        tbl[10] = mk(1,0,12'h201,8'hC3,3'd2,0,0,0,8'h00, 1,12'h202,1,12'h042,8'h03);
        tbl[11] = mk(1,0,12'h202,8'hC3,3'd3,0,0,1,8'h3C, 1,12'h203,1,12'h043,8'h04);
        tbl[12] = mk(1,0,12'h203,8'hC3,3'd4,1,0,1,8'h3D, 1,12'h204,1,12'h044,8'h05);
        tbl[13] = mk(1,0,12'h204,8'hC3,3'd4,1,1,1,8'h3E, 0,12'h000,0,12'h000,8'h00);
        tbl[14] = mk(1,1,12'h040,8'h01,3'd3,0,1,1,8'h3F, 0,12'h000,0,12'h000,8'h00);
        tbl[15] = mk(1,1,12'h041,8'h02,3'd2,0,1,1,8'h38, 0,12'h000,0,12'h000,8'h00);
        tbl[16] = mk(1,1,12'h042,8'h03,3'd1,0,1,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[17] = mk(1,1,12'h043,8'h04,3'd0,0,1,0,8'h00, 0,12'h000,0,12'h000,8'h00);
        tbl[18] = mk(0,0,12'h043,8'h04,3'd0,0,1,0,8'h00, 1,12'h300,1,12'h020,8'h22);
        tbl[19] = mk(1,0,12'h300,8'h04,3'd1,0,1,0,8'h00, 1,12'h301,1,12'h020,8'h33);
        tbl[20] = mk(1,0,12'h301,8'h04,3'd2,0,1,0,8'h00, 1,12'h020,0,12'h000,8'h00);
        tbl[21] = mk(1,0,12'h020,8'h04,3'd2,0,1,1,8'h3C, 0,12'h000,0,12'h000,8'h00);
        tbl[22] = mk(1,1,12'h020,8'h22,3'd1,0,1,1,8'h3D, 0,12'h000,0,12'h000,8'h00);
        tbl[23] = mk(1,1,12'h020,8'h33,3'd0,0,1,1,FWD_EXP, 0,12'h000,0,12'h000,8'h00);
        tbl[24] = mk(0,0,12'h020,8'h33,3'd0,0,1,0,8'h00, 0,12'h000,0,12'h000,8'h00);

        // Reset state, then idle
        #12;
        check_zero("rst");
        @(negedge CLK100MHz);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_zero("idle");
        end

        // Directed vectors: write/readback, simultaneous req, overflow, drain order, forwarding
        for (int i = 0; i < 25; i++) begin
            tick();
            check($sformatf("v%0d_en", i), 32'(mem_en), 32'(tbl[i].en));
            check($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].ma));
            check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].md));
            check($sformatf("v%0d_level", i), 32'(wr_level), 32'(tbl[i].lv));
            check($sformatf("v%0d_full", i), 32'(wr_full), 32'(tbl[i].fu));
            check($sformatf("v%0d_ovf", i), 32'(wr_overflow), 32'(tbl[i].ov));
            check($sformatf("v%0d_rv", i), 32'(rd_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) check($sformatf("v%0d_rdata", i), 32'(rd_data), 32'(tbl[i].rdat));
            drive(tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd);
        end

        // Eight back-to-back reads: one result per cycle, in order, no writes
        for (int j = 0; j <= 10; j++) begin
            tick();
            if (j >= 1 && j <= 8) begin
                check("s_en", 32'(mem_en), 32'd1);
                check("s_we", 32'(mem_we), 32'd0);
            end
            check("s_rv", 32'(rd_valid), 32'(j >= 3));
            if (j >= 3) check("s_rdata", 32'(rd_data), 32'(8'(j - 3) ^ 8'h3C));
            drive(j < 8, AW'(12'h400 + j), 1'b0, '0, '0);
        end

        // Reset while the FIFO is draining discards everything at once
        for (int j = 0; j < 3; j++) begin
            tick();
            drive(1'b1, 12'h500, 1'b1, AW'(12'h050 + j), 8'(8'hE0 + j));
        end
        tick();
        drive(1'b0, '0, 1'b0, '0, '0);
        tick();
        check("mid_en", 32'(mem_en), 32'd1);
        check("mid_level", 32'(wr_level), 32'd2);
        #2 rst = 1'b0;
        #1 check_zero("arst");
        @(negedge CLK100MHz);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("post_rv", 32'(rd_valid), 32'd0);
            check("post_en", 32'(mem_en), 32'd0);
        end

        // Randomized traffic on a small address window so forwarding and overflow both occur
        rd_pct = 50;
        wr_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 150 == 0) begin
                rd_pct = (c % 450 == 0) ? 90 : ((c % 300 == 0) ? 10 : 50);
                wr_pct = 20 + 35 * int'($urandom_range(2));
            end
            drive($urandom_range(99) < rd_pct, AW'(12'h020 + $urandom_range(7)),
                  $urandom_range(99) < wr_pct, AW'(12'h020 + $urandom_range(7)), 8'($urandom));
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        for (int j = 0; j < 10; j++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
